// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } arb_state_t;

    // Requester identities
    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_t;

    // Supported memory latency range (bounded by the 4-bit latency timer)
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;

    // Word accesses only: any nonzero byte offset is an alignment error
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable 4-bit down-counter; done is high while the count is zero.
module mem_lat_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_val,
    output logic       o_done
);

    logic [3:0] r_cnt;

    // Load on request, otherwise count down and park at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_done = (r_cnt == 4'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and
// load/store. One access in flight at a time, round-robin on ties,
// misaligned requests are answered with an error without touching memory.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic              if_err,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic              dm_err,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Out-of-range latencies are clamped so the 4-bit timer stays meaningful
    localparam int LAT_C = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                           (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
    // ISSUE loads LAT-1 so the last WAIT cycle coincides with valid read data
    localparam logic [3:0] LAT_LOAD = 4'(LAT_C - 1);

    arb_state_t        r_state;
    arb_state_t        w_next;
    req_id_t           r_id;
    req_id_t           r_last_gnt;
    req_id_t           w_gnt_id;
    logic              w_any_req;
    logic              w_gnt_misaligned;
    logic              w_timer_load;
    logic              w_timer_done;
    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    // Grant selection: a lone request wins, a tie goes to whoever was not served last
    always_comb begin
        w_any_req = if_req | dm_req;
        w_gnt_id  = REQ_FETCH;
        if (if_req && dm_req) begin
            w_gnt_id = (r_last_gnt == REQ_DATA) ? REQ_FETCH : REQ_DATA;
        end else if (dm_req) begin
            w_gnt_id = REQ_DATA;
        end
        w_gnt_misaligned = (w_gnt_id == REQ_DATA) ? is_misaligned(dm_addr[1:0])
                                                  : is_misaligned(if_addr[1:0]);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and state-decoded strobes (acks and mem_en are Moore outputs)
    always_comb begin
        w_next       = r_state;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        if_ack       = 1'b0;
        dm_ack       = 1'b0;
        if_err       = 1'b0;
        dm_err       = 1'b0;
        w_timer_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next = w_gnt_misaligned ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_en       = 1'b1;
                mem_we       = r_we;
                w_timer_load = 1'b1;
                w_next       = S_WAIT;
            end
            S_WAIT: begin
                if (w_timer_done) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if_ack = (r_id == REQ_FETCH);
                dm_ack = (r_id == REQ_DATA);
                if_err = (r_id == REQ_FETCH) && r_err;
                dm_err = (r_id == REQ_DATA) && r_err;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Latch the granted payload, capture read data, remember who was served
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id       <= REQ_FETCH;
            r_last_gnt <= REQ_DATA;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (r_state == S_IDLE && w_any_req) begin
                r_id  <= w_gnt_id;
                r_err <= w_gnt_misaligned;
                if (w_gnt_id == REQ_DATA) begin
                    r_addr  <= dm_addr;
                    r_we    <= dm_we;
                    r_wdata <= dm_wdata;
                end else begin
                    r_addr  <= if_addr;
                    r_we    <= 1'b0;
                    r_wdata <= '0;
                end
            end
            if (r_state == S_WAIT && w_timer_done && !r_we) begin
                if (r_id == REQ_FETCH) begin
                    r_if_rdata <= mem_rdata;
                end else begin
                    r_dm_rdata <= mem_rdata;
                end
            end
            if (r_state == S_RESP) begin
                r_last_gnt <= r_id;
            end
        end
    end

    mem_lat_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_timer_load),
        .i_val  (LAT_LOAD),
        .o_done (w_timer_done)
    );

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three builds (MEM_LAT 2, 1, 15) each with a
// fixed-latency memory model; the MEM_LAT=2 build is scoreboarded.
module tb_mem_port_arbiter;

    typedef struct {
        bit          d;
        bit          err;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_if;
        logic [31:0] exp_dm;
        int          t0;
        int          lat;
        int          en_off;
    } exp_t;

    typedef struct {
        bit          d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] exp_if;
        logic [31:0] exp_dm;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    logic        if_req    [3];
    logic [31:0] if_addr   [3];
    logic        if_ack    [3];
    logic        if_err    [3];
    logic [31:0] if_rdata  [3];
    logic        dm_req    [3];
    logic        dm_we     [3];
    logic [31:0] dm_addr   [3];
    logic [31:0] dm_wdata  [3];
    logic        dm_ack    [3];
    logic        dm_err    [3];
    logic [31:0] dm_rdata  [3];
    logic        mem_en    [3];
    logic        mem_we    [3];
    logic [31:0] mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[9];

    bit          prev_en = 1'b0;
    int          last_en_cyc = -1;
    logic [31:0] last_en_addr = '0;
    logic        last_en_we = 1'b0;
    logic [31:0] last_en_wdata = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        logic [15:0] en_sh = '0;
        logic [31:0] rd_sh [16];
        logic [31:0] mem [256];
        bit          minit = 1'b0;

        // Memory model: read word appears exactly L cycles after mem_en
        always @(posedge clk) begin
            en_sh    <= {en_sh[14:0], mem_en[g]};
            rd_sh[0] <= mem[mem_addr[g][9:2]];
            for (int k = 1; k < 16; k++) rd_sh[k] <= rd_sh[k-1];
            if (!minit) begin
                for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
                mem[4] <= 32'h00500093;
                minit  <= 1'b1;
            end else if (mem_en[g] && mem_we[g]) begin
                mem[mem_addr[g][9:2]] <= mem_wdata[g];
            end
        end

        assign mem_rdata[g] = en_sh[L-1] ? rd_sh[L-1] : 32'hBADBAD00;

        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_ack    (if_ack[g]),
            .if_err    (if_err[g]),
            .if_rdata  (if_rdata[g]),
            .dm_req    (dm_req[g]),
            .dm_we     (dm_we[g]),
            .dm_addr   (dm_addr[g]),
            .dm_wdata  (dm_wdata[g]),
            .dm_ack    (dm_ack[g]),
            .dm_err    (dm_err[g]),
            .dm_rdata  (dm_rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one request on the MEM_LAT=2 build, push its expectation, wait for its ack
    task automatic do_req(input vec_t v);
        exp_t e;
        bit   got;
        @(posedge clk); #1;
        if (v.d) begin
            dm_req[0] = 1'b1; dm_we[0] = v.we; dm_addr[0] = v.addr; dm_wdata[0] = v.wdata;
        end else begin
            if_req[0] = 1'b1; if_addr[0] = v.addr;
        end
        e.d = v.d; e.err = v.err; e.we = v.we; e.addr = v.addr; e.wdata = v.wdata;
        e.exp_if = v.exp_if; e.exp_dm = v.exp_dm; e.t0 = cyc;
        e.lat = v.err ? 1 : 4;
        e.en_off = v.err ? -1 : 1;
        sb.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (v.d ? dm_ack[0] : if_ack[0]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if_req[0] = 1'b0; dm_req[0] = 1'b0; dm_we[0] = 1'b0;
    endtask

    initial begin
        int   t0;
        bit   got;
        exp_t e;

        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            if_req[g] = 1'b0; if_addr[g] = '0; dm_req[g] = 1'b0; dm_we[g] = 1'b0;
            dm_addr[g] = '0; dm_wdata[g] = '0;
        end

        // Scoreboard monitor for the MEM_LAT=2 build
        fork
            forever begin
                @(negedge clk);
                if (mem_en[0]) begin
                    chk("mem_en_back_to_back", {31'b0, prev_en}, 32'd0);
                    last_en_cyc   = cyc;
                    last_en_addr  = mem_addr[0];
                    last_en_we    = mem_we[0];
                    last_en_wdata = mem_wdata[0];
                end
                prev_en = mem_en[0];
                if (if_ack[0] || dm_ack[0]) begin
                    chk("ack_overlap", {31'b0, if_ack[0] & dm_ack[0]}, 32'd0);
                    if (sb.size() == 0) begin
                        chk("unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("ack_dm", {31'b0, dm_ack[0]}, {31'b0, e.d});
                        chk("ack_err", {31'b0, e.d ? dm_err[0] : if_err[0]}, {31'b0, e.err});
                        chk("if_rdata", if_rdata[0], e.exp_if);
                        chk("dm_rdata", dm_rdata[0], e.exp_dm);
                        chk("latency", 32'(cyc - e.t0), 32'(e.lat));
                        if (e.en_off < 0) begin
                            chk("no_mem_en", {31'b0, last_en_cyc < e.t0}, 32'd1);
                        end else begin
                            chk("mem_en_cycle", 32'(last_en_cyc - e.t0), 32'(e.en_off));
                            chk("mem_addr", last_en_addr, e.addr);
                            chk("mem_we", {31'b0, last_en_we}, {31'b0, e.we});
                            if (e.we) chk("mem_wdata", last_en_wdata, e.wdata);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en", {31'b0, mem_en[0]}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we[0]}, 32'd0);
        chk("rst_if_ack", {31'b0, if_ack[0]}, 32'd0);
        chk("rst_dm_ack", {31'b0, dm_ack[0]}, 32'd0);
        chk("rst_if_err", {31'b0, if_err[0]}, 32'd0);
        chk("rst_dm_err", {31'b0, dm_err[0]}, 32'd0);
        chk("rst_mem_addr", mem_addr[0], 32'd0);
        chk("rst_mem_wdata", mem_wdata[0], 32'd0);
        chk("rst_if_rdata", if_rdata[0], 32'd0);
        chk("rst_dm_rdata", dm_rdata[0], 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Tie from reset: fetch, then data, then fetch again while requests stay up
        @(posedge clk); #1;
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h84;
        t0 = cyc;
        sb.push_back('{1'b0, 1'b0, 1'b0, 32'h10,  32'h0, 32'h00500093, 32'h0,        t0, 4,  1});
        sb.push_back('{1'b1, 1'b0, 1'b0, 32'h84,  32'h0, 32'h00500093, 32'hC0DE0021, t0, 9,  6});
        sb.push_back('{1'b0, 1'b0, 1'b0, 32'h3FC, 32'h0, 32'hC0DE00FF, 32'hC0DE0021, t0, 14, 11});
        repeat (5) @(posedge clk); #1;
        if_addr[0] = 32'h3FC;
        repeat (5) @(posedge clk); #1;
        dm_req[0] = 1'b0;
        repeat (5) @(posedge clk); #1;
        if_req[0] = 1'b0;
        repeat (3) @(posedge clk);
        chk("sb_drained_tie", 32'(sb.size()), 32'd0);

        // Table of single requests: {data, we, addr, wdata, err, if_rdata, dm_rdata}
        vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        1'b0, 32'h00500093, 32'hC0DE0021};
        vecs[1] = '{1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 32'h00500093, 32'hC0DE0021};
        vecs[2] = '{1'b1, 1'b0, 32'h203, 32'h0,        1'b1, 32'h00500093, 32'hC0DE0021};
        vecs[3] = '{1'b1, 1'b0, 32'h200, 32'h0,        1'b0, 32'h00500093, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b0, 32'h84,  32'h0,        1'b0, 32'hC0DE0021, 32'hDEADBEEF};
        vecs[5] = '{1'b0, 1'b0, 32'h102, 32'h0,        1'b1, 32'hC0DE0021, 32'hDEADBEEF};
        vecs[6] = '{1'b1, 1'b1, 32'h84,  32'h12345678, 1'b0, 32'hC0DE0021, 32'hDEADBEEF};
        vecs[7] = '{1'b0, 1'b0, 32'h84,  32'h0,        1'b0, 32'h12345678, 32'hDEADBEEF};
        vecs[8] = '{1'b1, 1'b0, 32'h3FC, 32'h0,        1'b0, 32'h12345678, 32'hC0DE00FF};
        for (int i = 0; i < 9; i++) do_req(vecs[i]);
        repeat (2) @(posedge clk);
        chk("sb_drained_table", 32'(sb.size()), 32'd0);

        // Reset in the middle of WAIT: everything clears at once, no ack follows
        @(posedge clk); #1;
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        repeat (2) @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("midrst_mem_en", {31'b0, mem_en[0]}, 32'd0);
        chk("midrst_if_ack", {31'b0, if_ack[0]}, 32'd0);
        chk("midrst_if_rdata", if_rdata[0], 32'd0);
        chk("midrst_dm_rdata", dm_rdata[0], 32'd0);
        chk("midrst_mem_addr", mem_addr[0], 32'd0);
        if_req[0] = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        do_req('{1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h00500093, 32'h0});
        repeat (2) @(posedge clk);
        chk("sb_drained_reset", 32'(sb.size()), 32'd0);

        // Latency extremes on the MEM_LAT=1 and MEM_LAT=15 builds
        for (int g = 1; g < 3; g++) begin
            @(posedge clk); #1;
            if_req[g] = 1'b1; if_addr[g] = 32'h10;
            t0 = cyc;
            got = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (if_ack[g]) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                chk("lat_ack_timeout", 32'd0, 32'd1);
            end else begin
                chk("lat_build_latency", 32'(cyc - t0), (g == 1) ? 32'd3 : 32'd17);
                chk("lat_build_rdata", if_rdata[g], 32'h00500093);
                chk("lat_build_err", {31'b0, if_err[g]}, 32'd0);
            end
            @(posedge clk); #1;
            if_req[g] = 1'b0;
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single instruction/data memory port between the instruction-fetch requester and the load/store (data) requester. Issues one access at a time to a fixed-latency memory, tracks the latency, and routes the returned word back with a one-cycle acknowledge. Round-robin arbitration on ties. Sits between the fetch/memory-access stages and the memory model.

## Interface
- `ADDR_W`, 32, address width (byte address).
- `DATA_W`, 32, data width.
- `MEM_LAT`, 2, cycles from `mem_en` to valid `mem_rdata`; legal range 1..15.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_ack`  out  1  one-cycle pulse: fetch complete.
- `if_err`  out  1  valid with `if_ack`: misaligned address.
- `if_rdata`  out  DATA_W  fetched word; valid with `if_ack`, held until next fetch ack.
- `dm_req`, `dm_we`  in  1  data request, write enable; held with payload until `dm_ack`.
- `dm_addr`  in  ADDR_W, `dm_wdata`  in  DATA_W  data payload.
- `dm_ack`, `dm_err`  out  1  as for fetch.
- `dm_rdata`  out  DATA_W  read word; updates only on successful reads.
- `mem_en`, `mem_we`  out  1  memory access strobe (one cycle), write enable.
- `mem_addr`  out  ADDR_W, `mem_wdata`  out  DATA_W  memory payload.
- `mem_rdata`  in  DATA_W  memory read data, valid exactly MEM_LAT cycles after `mem_en`.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: sample `if_req`/`dm_req`. None -> stay. One -> grant it. Both -> grant the one not granted last (`last_gnt`, reset = DATA, so fetch wins the first tie). On grant latch id, addr, we, wdata.
- Alignment: `addr[1:0] != 0` -> skip memory, go to RESP with err=1, no `mem_en`.
- ISSUE: `mem_en`=1 with latched payload; load counter with MEM_LAT-1; go WAIT (MEM_LAT=1: counter 0, WAIT lasts one cycle).
- WAIT: decrement; at count 0 register `mem_rdata` into the granted requester's rdata (reads only), go RESP.
- RESP: pulse granted `*_ack` (plus `*_err`), update `last_gnt`, go IDLE. Requests are not sampled in RESP.
- Writes follow the same path and latency; `dm_rdata` unchanged on writes and on errors.
- Requester rule: payload stable while req high; a req still high in the cycle after ack is a new request.

## Timing
- Reset (async): state IDLE; `mem_en`, `mem_we`, `if_ack`, `dm_ack`, `if_err`, `dm_err` = 0; `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` = 0; `last_gnt` = DATA. In-flight access discarded; no ack ever issued for it.
- Request sampled in IDLE at cycle 0 -> `mem_en` cycle 1 -> `mem_rdata` cycle 1+MEM_LAT -> ack cycle 2+MEM_LAT (latency MEM_LAT+2).
- Misaligned: ack+err at cycle 1.
- Back-to-back throughput: one access per MEM_LAT+3 cycles (RESP->IDLE costs one cycle).
- `mem_en` is never high on two consecutive cycles; never more than one access outstanding.
- `if_ack` and `dm_ack` are never high in the same cycle.

## Structure
- Package `mem_arb_pkg`: state enum, requester-id enum (FETCH, DATA), MEM_LAT min/max constants, alignment-check function.
- Sub-module `mem_lat_timer`: loadable 4-bit down-counter with `done` flag; arbiter FSM and routing stay in the top.

## Test plan
- Single fetch, MEM_LAT=2, `if_addr`=0x10, memory returns 0x00500093 -> `mem_en` cycle 1, `if_ack`=1 cycle 4, `if_rdata`=0x00500093, `if_err`=0.
- Simultaneous `if_req`/`dm_req` from reset, held -> fetch served first, data second, then fetch again (alternation); acks never overlap.
- Data write `dm_addr`=0x200, `dm_wdata`=0xDEADBEEF -> `mem_we`=1 with `mem_en`, `dm_ack` at MEM_LAT+2, `dm_rdata` unchanged.
- Misaligned `dm_addr`=0x203 read -> no `mem_en`, `dm_ack`=`dm_err`=1 at cycle 1, `dm_rdata` unchanged.
- Assert `rst` during WAIT -> outputs zero immediately, no ack; after release, a new fetch completes with normal latency.
- MEM_LAT=1 and MEM_LAT=15 builds -> ack at cycles 3 and 17 respectively.
